// File: rtl/pipeline_hazard_ctrl_pkg.sv
// pipeline_hazard_ctrl_pkg: shared state encodings, control bundle and hazard helper.
//   hz_state_e  FSM encodings RUN/MEM_WAIT/ERROR (2'd3 is illegal)
//   hz_ctrl_t   packed stall/flush bundle, MSB first:
//               pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush
//   CTRL_*      output patterns for each priority level
//   load_use()  load-use hazard detector
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        HZ_RUN      = 2'd0,
        HZ_MEM_WAIT = 2'd1,
        HZ_ERROR    = 2'd2,
        HZ_ILLEGAL  = 2'd3
    } hz_state_e;

    typedef struct packed {
        logic pc_stall;
        logic if_id_stall;
        logic if_id_flush;
        logic id_ex_stall;
        logic id_ex_flush;
        logic ex_mem_stall;
        logic mem_wb_flush;
    } hz_ctrl_t;

    localparam hz_ctrl_t CTRL_IDLE     = 7'b000_0000;
    // Whole front of the pipe holds; MEM_WB gets a bubble so WB is not repeated.
    localparam hz_ctrl_t CTRL_FREEZE   = 7'b110_1011;
    localparam hz_ctrl_t CTRL_BRANCH   = 7'b001_0100;
    localparam hz_ctrl_t CTRL_LOAD_USE = 7'b110_0100;

    // x0 is never a real producer, so a load to x0 can never create a hazard.
    function automatic logic load_use(
        input logic [4:0] rs1,
        input logic [4:0] rs2,
        input logic       use_rs1,
        input logic       use_rs2,
        input logic [4:0] rd,
        input logic       mem_read
    );
        return mem_read && (rd != 5'd0) &&
               ((use_rs1 && (rs1 == rd)) || (use_rs2 && (rs2 == rd)));
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: pipeline <-> hazard controller signal bundle.
//   pipeline -> ctrl: id_rs1/id_rs2/id_use_rs1/id_use_rs2, ex_rd, ex_mem_read, ex_br_taken,
//                     mem_req, mem_ready
//   ctrl -> pipeline: pc_stall, if_id_stall/flush, id_ex_stall/flush, ex_mem_stall, mem_wb_flush,
//                     mem_err, state, stall_cnt, flush_cnt
//   master = pipeline side, slave = controller side
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic [4:0]       ex_rd;
    logic             ex_mem_read;
    logic             ex_br_taken;
    logic             mem_req;
    logic             mem_ready;
    logic             pc_stall;
    logic             if_id_stall;
    logic             if_id_flush;
    logic             id_ex_stall;
    logic             id_ex_flush;
    logic             ex_mem_stall;
    logic             mem_wb_flush;
    logic             mem_err;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read, ex_br_taken,
               mem_req, mem_ready,
        input  pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall,
               mem_wb_flush, mem_err, state, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read, ex_br_taken,
               mem_req, mem_ready,
        output pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall,
               mem_wb_flush, mem_err, state, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// pipeline_hazard_ctrl_sat_counter: W-bit event counter that sticks at all-ones.
//   clk    system clock
//   rst    synchronous active-high clear
//   inc_i  count this cycle
//   q_o    current count
module pipeline_hazard_ctrl_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] q_q;

    always_ff @(posedge clk) begin
        if (rst) q_q <= '0;
        else if (inc_i && !(&q_q)) q_q <= q_q + W'(1);
    end

    assign q_o = q_q;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush scheduler for the 5-stage pipeline.
//   clk    system clock, rising edge
//   rst    synchronous active-high reset
//   hz_io  slave side of pipeline_hazard_ctrl_if: hazard inputs in, stall/flush controls,
//          sticky mem_err, FSM state and saturating stall/flush statistics out
// Stall/flush outputs are combinational; state and mem_err are registered.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 256,
    parameter int CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    pipeline_hazard_ctrl_if.slave hz_io
);
    localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    hz_state_e state_q;
    logic [TW-1:0] tmo_q;
    logic mem_err_q;
    logic freeze;
    logic lu;
    logic timeout_hit;
    hz_ctrl_t ctrl;

    assign lu = load_use(hz_io.id_rs1, hz_io.id_rs2, hz_io.id_use_rs1, hz_io.id_use_rs2,
                         hz_io.ex_rd, hz_io.ex_mem_read);

    // A same-cycle mem_ready completes the access without any freeze.
    assign freeze = (state_q == HZ_RUN && hz_io.mem_req && !hz_io.mem_ready) ||
                    (state_q == HZ_MEM_WAIT && !hz_io.mem_ready) ||
                    (state_q == HZ_ERROR);

    assign timeout_hit = (MEM_TIMEOUT != 0) && (tmo_q == TW'(MEM_TIMEOUT - 1));

    // Branch beats load-use: the dependent instruction is on the wrong path.
    // A branch seen during freeze is simply re-presented by the held EX stage later.
    assign ctrl = rst         ? CTRL_IDLE :
                  freeze      ? CTRL_FREEZE :
                  hz_io.ex_br_taken ? CTRL_BRANCH :
                  lu          ? CTRL_LOAD_USE : CTRL_IDLE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= HZ_RUN;
            tmo_q     <= '0;
            mem_err_q <= 1'b0;
        end else begin
            case (state_q)
                HZ_RUN: begin
                    if (hz_io.mem_req && !hz_io.mem_ready) begin
                        state_q <= HZ_MEM_WAIT;
                        tmo_q   <= '0;
                    end
                end
                HZ_MEM_WAIT: begin
                    if (hz_io.mem_ready) begin
                        state_q <= HZ_RUN;
                    end else if (timeout_hit) begin
                        state_q   <= HZ_ERROR;
                        mem_err_q <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                HZ_ERROR: mem_err_q <= 1'b1;
                default:  state_q   <= HZ_RUN;
            endcase
        end
    end

    assign hz_io.pc_stall     = ctrl.pc_stall;
    assign hz_io.if_id_stall  = ctrl.if_id_stall;
    assign hz_io.if_id_flush  = ctrl.if_id_flush;
    assign hz_io.id_ex_stall  = ctrl.id_ex_stall;
    assign hz_io.id_ex_flush  = ctrl.id_ex_flush;
    assign hz_io.ex_mem_stall = ctrl.ex_mem_stall;
    assign hz_io.mem_wb_flush = ctrl.mem_wb_flush;
    assign hz_io.mem_err      = mem_err_q;
    assign hz_io.state        = state_q;

    pipeline_hazard_ctrl_sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (ctrl.pc_stall),
        .q_o   (hz_io.stall_cnt)
    );

    pipeline_hazard_ctrl_sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (ctrl.if_id_flush),
        .q_o   (hz_io.flush_cnt)
    );
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: self-checking bench for pipeline_hazard_ctrl (MEM_TIMEOUT=4, CNT_W=4).
// Expected {outputs, state, mem_err} words are queued as each cycle is driven and popped
// when the outputs are sampled 1 ns later, mid-cycle.
module tb_pipeline_hazard_ctrl;
    localparam int CW = 4;
    localparam logic [6:0] NONE = 7'b000_0000;
    localparam logic [6:0] FRZ  = 7'b110_1011;
    localparam logic [6:0] BR   = 7'b001_0100;
    localparam logic [6:0] LU   = 7'b110_0100;

    typedef logic [9:0] exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    exp_t sb[$];

    pipeline_hazard_ctrl_if #(.CNT_W(CW)) hz_if ();

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst   (rst),
        .hz_io (hz_if)
    );

    always #5 clk = ~clk;

    function automatic exp_t observe();
        return {hz_if.pc_stall, hz_if.if_id_stall, hz_if.if_id_flush, hz_if.id_ex_stall,
                hz_if.id_ex_flush, hz_if.ex_mem_stall, hz_if.mem_wb_flush,
                hz_if.state, hz_if.mem_err};
    endfunction

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                         input logic u2, input logic [4:0] rd, input logic mr,
                         input logic br, input logic mq, input logic my);
        hz_if.id_rs1      = rs1;
        hz_if.id_rs2      = rs2;
        hz_if.id_use_rs1  = u1;
        hz_if.id_use_rs2  = u2;
        hz_if.ex_rd       = rd;
        hz_if.ex_mem_read = mr;
        hz_if.ex_br_taken = br;
        hz_if.mem_req     = mq;
        hz_if.mem_ready   = my;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 1, 1, 0);
        #1;
        checks++;
        if (observe() >> 3 !== 10'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected %b", observe() >> 3, 10'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checks++;
        if ({hz_if.state, hz_if.mem_err, hz_if.stall_cnt, hz_if.flush_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_state: got st=%0d err=%0d sc=%0d fc=%0d expected all 0",
                     hz_if.state, hz_if.mem_err, hz_if.stall_cnt, hz_if.flush_cnt);
        end
    endtask

    task automatic test_load_use();
        exp_t e;
        exp_t g;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (i == 0) drive(0, 5, 0, 1, 5, 1, 0, 0, 0);
            else        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
            sb.push_back({(i == 0) ? LU : NONE, 2'd0, 1'b0});
            #1;
            e = sb.pop_front();
            g = observe();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL load_use[%0d]: got %b expected %b", i, g, e);
            end
        end
        @(negedge clk);
        checks++;
        if (hz_if.stall_cnt !== CW'(1)) begin
            errors++;
            $display("FAIL load_use_stall_cnt: got %0d expected 1", hz_if.stall_cnt);
        end
    endtask

    task automatic test_no_hazard();
        logic [4:0] rd_t[4]  = '{5'd0, 5'd3, 5'd3, 5'd3};
        logic       u1_t[4]  = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic       mr_t[4]  = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic [6:0] exp_t4[4] = '{NONE, NONE, NONE, LU};
        exp_t e;
        exp_t g;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(rd_t[i], 0, u1_t[i], 0, rd_t[i], mr_t[i], 0, 0, 0);
            sb.push_back({exp_t4[i], 2'd0, 1'b0});
            #1;
            e = sb.pop_front();
            g = observe();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL no_hazard[%0d]: got %b expected %b", i, g, e);
            end
        end
    endtask

    task automatic test_branch();
        exp_t e;
        exp_t g;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (i == 0) drive(7, 0, 1, 0, 7, 1, 1, 0, 0);
            else        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
            sb.push_back({(i == 0) ? BR : NONE, 2'd0, 1'b0});
            #1;
            e = sb.pop_front();
            g = observe();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL branch[%0d]: got %b expected %b", i, g, e);
            end
        end
        @(negedge clk);
        checks++;
        if ({hz_if.flush_cnt, hz_if.stall_cnt} !== {CW'(1), CW'(0)}) begin
            errors++;
            $display("FAIL branch_cnts: got fc=%0d sc=%0d expected fc=1 sc=0",
                     hz_if.flush_cnt, hz_if.stall_cnt);
        end
    endtask

    task automatic test_mem_wait();
        exp_t e;
        exp_t g;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive(0, 0, 0, 0, 0, 0, 0, i < 4, i == 3);
            sb.push_back({(i < 3) ? FRZ : NONE, (i >= 1 && i <= 3) ? 2'd1 : 2'd0, 1'b0});
            #1;
            e = sb.pop_front();
            g = observe();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL mem_wait[%0d]: got %b expected %b", i, g, e);
            end
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            drive(0, 0, 0, 0, 0, 0, 0, i == 0, i == 0);
            sb.push_back({NONE, 2'd0, 1'b0});
            #1;
            e = sb.pop_front();
            g = observe();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL mem_same_cycle[%0d]: got %b expected %b", i, g, e);
            end
        end
        checks++;
        if (hz_if.stall_cnt !== CW'(3)) begin
            errors++;
            $display("FAIL mem_wait_stall_cnt: got %0d expected 3", hz_if.stall_cnt);
        end
    endtask

    task automatic test_timeout();
        exp_t e;
        exp_t g;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive(0, 0, 0, 0, 0, 0, i >= 6, i < 6, 0);
            sb.push_back({FRZ, (i == 0) ? 2'd0 : (i < 5) ? 2'd1 : 2'd2, i >= 5});
            #1;
            e = sb.pop_front();
            g = observe();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL timeout[%0d]: got %b expected %b", i, g, e);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 1, 1, 0);
        #1;
        checks++;
        if (observe() >> 3 !== 10'd0) begin
            errors++;
            $display("FAIL timeout_rst_outputs: got %b expected 0", observe() >> 3);
        end
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checks++;
        if ({hz_if.state, hz_if.mem_err, hz_if.stall_cnt, hz_if.flush_cnt} !== '0) begin
            errors++;
            $display("FAIL timeout_recover: got st=%0d err=%0d sc=%0d fc=%0d expected all 0",
                     hz_if.state, hz_if.mem_err, hz_if.stall_cnt, hz_if.flush_cnt);
        end
    endtask

    task automatic test_branch_in_wait();
        exp_t e;
        exp_t g;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(0, 0, 0, 0, 0, 0, i < 3, i < 3, i == 2);
            sb.push_back({(i < 2) ? FRZ : (i == 2) ? BR : NONE,
                          (i == 1 || i == 2) ? 2'd1 : 2'd0, 1'b0});
            #1;
            e = sb.pop_front();
            g = observe();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL branch_in_wait[%0d]: got %b expected %b", i, g, e);
            end
        end
        checks++;
        if ({hz_if.flush_cnt, hz_if.stall_cnt} !== {CW'(1), CW'(2)}) begin
            errors++;
            $display("FAIL branch_in_wait_cnts: got fc=%0d sc=%0d expected fc=1 sc=2",
                     hz_if.flush_cnt, hz_if.stall_cnt);
        end
    endtask

    task automatic test_saturation();
        exp_t e;
        exp_t g;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i < 20) drive(9, 0, 1, 0, 9, 1, 0, 0, 0);
            else        drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
            sb.push_back({(i < 20) ? LU : BR, 2'd0, 1'b0});
            #1;
            e = sb.pop_front();
            g = observe();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL saturation[%0d]: got %b expected %b", i, g, e);
            end
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if ({hz_if.stall_cnt, hz_if.flush_cnt} !== {CW'(15), CW'(15)}) begin
            errors++;
            $display("FAIL saturation_cnts: got sc=%0d fc=%0d expected 15 15",
                     hz_if.stall_cnt, hz_if.flush_cnt);
        end
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_load_use();
        test_no_hazard();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_branch_in_wait();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
